// File: rtl/slv_fsm_pkg.sv
// Shared types and helpers for the multi-channel register-slave FSM.
// Imported by the top and any sub-blocks that need the state encoding.
package slv_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    ERR_RSP  = 2'd2
  } state_e;

  // A disabled timeout (0) still gets a 1-bit counter so widths stay legal
  function automatic int cnt_width(input int tc);
    return (tc < 1) ? 1 : $clog2(tc + 1);
  endfunction

  // Callers zero-extend their select vector to 64 bits
  function automatic logic is_onehot(input logic [63:0] v);
    return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
  endfunction

endpackage

// File: rtl/slv_rsp_mux.sv
// One-hot AND-OR select of per-channel ack and read data.
// The select is the latched channel one-hot; at most one bit is set.
module slv_rsp_mux #(
  parameter int NUM_SLV    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic [NUM_SLV-1:0]            sel,
  input  logic [NUM_SLV-1:0]            ack_vld,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] rd_data,
  output logic                          sel_ack,
  output logic [DATA_WIDTH-1:0]         sel_rd_data
);

  // AND-OR reduce the selected channel's ack and data
  always_comb begin
    sel_ack     = |(ack_vld & sel);
    sel_rd_data = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel_rd_data = sel_rd_data |
        (rd_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel[i]}});
    end
  end

endmodule

// File: rtl/slv_fsm_mc.sv
// Multi-channel register-slave access FSM with timeout and error response.
// One request in flight; forwarded to a one-hot selected channel.
module slv_fsm_mc
  import slv_fsm_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SLV     = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          mst__fsm__req_vld,
  input  logic [ADDR_WIDTH-1:0]         mst__fsm__addr,
  input  logic                          mst__fsm__wr_en,
  input  logic                          mst__fsm__rd_en,
  input  logic [DATA_WIDTH-1:0]         mst__fsm__wr_data,
  input  logic [NUM_SLV-1:0]            mst__fsm__slv_sel,
  input  logic                          mst__fsm__sync_reset,
  output logic                          fsm__mst__ack_vld,
  output logic                          fsm__mst__err,
  output logic [DATA_WIDTH-1:0]         fsm__mst__rd_data,
  output logic                          fsm__mst__busy,
  output logic [NUM_SLV-1:0]            fsm__slv__req_vld,
  output logic [ADDR_WIDTH-1:0]         fsm__slv__addr,
  output logic [DATA_WIDTH-1:0]         fsm__slv__wr_data,
  output logic                          fsm__slv__wr_en,
  output logic                          fsm__slv__rd_en,
  input  logic [NUM_SLV-1:0]            slv__fsm__ack_vld,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] slv__fsm__rd_data,
  output logic                          fsm__slv__sync_reset
);

  localparam int CW = cnt_width(TIMEOUT_CYC);
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TO_EN ? TIMEOUT_CYC - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e                state_ff, state_nxt;
  logic [CW-1:0]         cnt_ff;
  logic [ADDR_WIDTH-1:0] addr_ff;
  logic [DATA_WIDTH-1:0] wdata_ff;
  logic                  wr_ff, rd_ff;
  logic [NUM_SLV-1:0]    sel_ff;

  logic                  legal;
  logic                  accept;
  logic                  sel_ack;
  logic [DATA_WIDTH-1:0] sel_rd_data;
  logic                  timeout;

  assign fsm__slv__sync_reset = mst__fsm__sync_reset;
  assign fsm__mst__busy       = (state_ff != IDLE);

  assign legal = is_onehot(64'(mst__fsm__slv_sel)) &&
                 (mst__fsm__wr_en ^ mst__fsm__rd_en);

  assign timeout = TO_EN && (cnt_ff == CNT_LAST);

  slv_rsp_mux #(
    .NUM_SLV    (NUM_SLV),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rsp_mux (
    .sel         (sel_ff),
    .ack_vld     (slv__fsm__ack_vld),
    .rd_data     (slv__fsm__rd_data),
    .sel_ack     (sel_ack),
    .sel_rd_data (sel_rd_data)
  );

  // State, timeout counter and latched request fields
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_ff <= IDLE;
      cnt_ff   <= '0;
      addr_ff  <= '0;
      wdata_ff <= '0;
      wr_ff    <= 1'b0;
      rd_ff    <= 1'b0;
      sel_ff   <= '0;
    end else if (mst__fsm__sync_reset) begin
      state_ff <= IDLE;
      cnt_ff   <= '0;
      addr_ff  <= '0;
      wdata_ff <= '0;
      wr_ff    <= 1'b0;
      rd_ff    <= 1'b0;
      sel_ff   <= '0;
    end else begin
      state_ff <= state_nxt;
      if (accept) begin
        cnt_ff   <= '0;
        addr_ff  <= mst__fsm__addr;
        wdata_ff <= mst__fsm__wr_data;
        wr_ff    <= mst__fsm__wr_en;
        rd_ff    <= mst__fsm__rd_en;
        sel_ff   <= mst__fsm__slv_sel;
      end else if (state_ff == WAIT_ACK && cnt_ff != CNT_MAX) begin
        cnt_ff <= cnt_ff + 1'b1;
      end
    end
  end

  // Next state, master response and slave-side outputs
  always_comb begin
    state_nxt         = state_ff;
    accept            = 1'b0;
    fsm__mst__ack_vld = 1'b0;
    fsm__mst__err     = 1'b0;
    fsm__mst__rd_data = '0;
    fsm__slv__req_vld = '0;
    fsm__slv__addr    = '0;
    fsm__slv__wr_data = '0;
    fsm__slv__wr_en   = 1'b0;
    fsm__slv__rd_en   = 1'b0;
    unique case (state_ff)
      IDLE: begin
        if (mst__fsm__req_vld && !mst__fsm__sync_reset) begin
          if (legal) begin
            accept    = 1'b1;
            state_nxt = WAIT_ACK;
          end else begin
            state_nxt = ERR_RSP;
          end
        end
      end
      WAIT_ACK: begin
        fsm__slv__req_vld = sel_ff;
        fsm__slv__addr    = addr_ff;
        fsm__slv__wr_data = wdata_ff;
        fsm__slv__wr_en   = wr_ff;
        fsm__slv__rd_en   = rd_ff;
        if (sel_ack) begin
          state_nxt = IDLE;
          if (!mst__fsm__sync_reset) begin
            fsm__mst__ack_vld = 1'b1;
            fsm__mst__rd_data = rd_ff ? sel_rd_data : '0;
          end
        end else if (timeout) begin
          state_nxt = ERR_RSP;
        end
      end
      ERR_RSP: begin
        state_nxt = IDLE;
        if (!mst__fsm__sync_reset) begin
          fsm__mst__ack_vld = 1'b1;
          fsm__mst__err     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (mst__fsm__sync_reset) state_nxt = IDLE;
  end

endmodule

// File: tb/tb_slv_fsm_mc.sv
// Directed self-checking bench for slv_fsm_mc.
// Inputs change 1ns after posedge; outputs checked 1ns later.
module tb_slv_fsm_mc;

  localparam int AW = 64;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TC = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_vld;
  logic [AW-1:0] addr;
  logic          wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic [NS-1:0] slv_sel;
  logic          sync_reset;
  logic          m_ack, m_err, m_busy;
  logic [DW-1:0] m_rd_data;
  logic [NS-1:0] s_req;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wr_data;
  logic          s_wr_en, s_rd_en, s_sync;
  logic [NS-1:0] s_ack;
  logic [NS*DW-1:0] s_rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  slv_fsm_mc #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .NUM_SLV     (NS),
    .TIMEOUT_CYC (TC)
  ) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .mst__fsm__req_vld    (req_vld),
    .mst__fsm__addr       (addr),
    .mst__fsm__wr_en      (wr_en),
    .mst__fsm__rd_en      (rd_en),
    .mst__fsm__wr_data    (wr_data),
    .mst__fsm__slv_sel    (slv_sel),
    .mst__fsm__sync_reset (sync_reset),
    .fsm__mst__ack_vld    (m_ack),
    .fsm__mst__err        (m_err),
    .fsm__mst__rd_data    (m_rd_data),
    .fsm__mst__busy       (m_busy),
    .fsm__slv__req_vld    (s_req),
    .fsm__slv__addr       (s_addr),
    .fsm__slv__wr_data    (s_wr_data),
    .fsm__slv__wr_en      (s_wr_en),
    .fsm__slv__rd_en      (s_rd_en),
    .slv__fsm__ack_vld    (s_ack),
    .slv__fsm__rd_data    (s_rd_data),
    .fsm__slv__sync_reset (s_sync)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req_vld = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    slv_sel = '0;
    addr    = '0;
    wr_data = '0;
  endtask

  task automatic issue(input logic [NS-1:0] sel, input logic w,
                       input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    req_vld = 1'b1;
    slv_sel = sel;
    wr_en   = w;
    rd_en   = r;
    addr    = a;
    wr_data = d;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, 64'(m_ack), 64'd0);
    chk({tag, "_busy"}, 64'(m_busy), 64'd0);
    chk({tag, "_sreq"}, 64'(s_req), 64'd0);
  endtask

  task automatic illegal(input string tag, input logic [NS-1:0] sel,
                         input logic w, input logic r);
    issue(sel, w, r, 64'h40, 32'h5);
    #1;
    chk({tag, "_T_ack"}, 64'(m_ack), 64'd0);
    tick();
    idle_in();
    #1;
    chk({tag, "_ack"}, 64'(m_ack), 64'd1);
    chk({tag, "_err"}, 64'(m_err), 64'd1);
    chk({tag, "_rd"}, 64'(m_rd_data), 64'd0);
    chk({tag, "_sreq"}, 64'(s_req), 64'd0);
    tick();
    #1;
    chk_quiet({tag, "_after"});
  endtask

  initial begin
    rstn       = 1'b0;
    sync_reset = 1'b0;
    s_ack      = '0;
    s_rd_data  = {32'hAAAA0003, 32'hDEADBEEF, 32'h11111111, 32'h12345678};
    idle_in();
    #2;
    chk_quiet("rst");
    chk("rst_err", 64'(m_err), 64'd0);
    chk("rst_addr", s_addr, 64'd0);
    chk("rst_rd", 64'(m_rd_data), 64'd0);
    #20;
    rstn = 1'b1;
    tick();

    // read channel 2, slave acks three cycles after the request
    issue(4'b0100, 1'b0, 1'b1, 64'h1000, 32'h0);
    #1;
    chk("rd_T_busy", 64'(m_busy), 64'd0);
    tick();
    idle_in();
    #1;
    chk("rd_T1_sreq", 64'(s_req), 64'h4);
    chk("rd_T1_busy", 64'(m_busy), 64'd1);
    chk("rd_T1_addr", s_addr, 64'h1000);
    chk("rd_T1_rden", 64'(s_rd_en), 64'd1);
    chk("rd_T1_ack", 64'(m_ack), 64'd0);
    tick();
    #1;
    chk("rd_T2_sreq", 64'(s_req), 64'h4);
    chk("rd_T2_ack", 64'(m_ack), 64'd0);
    tick();
    s_ack = 4'b0100;
    #1;
    chk("rd_T3_sreq", 64'(s_req), 64'h4);
    chk("rd_T3_ack", 64'(m_ack), 64'd1);
    chk("rd_T3_err", 64'(m_err), 64'd0);
    chk("rd_T3_data", 64'(m_rd_data), 64'hDEADBEEF);
    tick();
    s_ack = '0;
    #1;
    chk_quiet("rd_T4");
    chk("rd_T4_data", 64'(m_rd_data), 64'd0);

    // write channel 0, ack in first wait cycle
    issue(4'b0001, 1'b1, 1'b0, 64'h2004, 32'hCAFEF00D);
    tick();
    idle_in();
    s_ack = 4'b0001;
    #1;
    chk("wr_ack", 64'(m_ack), 64'd1);
    chk("wr_err", 64'(m_err), 64'd0);
    chk("wr_rd", 64'(m_rd_data), 64'd0);
    chk("wr_wdata", 64'(s_wr_data), 64'hCAFEF00D);
    chk("wr_wren", 64'(s_wr_en), 64'd1);
    chk("wr_sreq", 64'(s_req), 64'h1);
    tick();
    s_ack = '0;
    #1;
    chk_quiet("wr_after");

    // timeout on channel 1; channel 3 ack mid-wait is ignored
    issue(4'b0010, 1'b0, 1'b1, 64'h3000, 32'h0);
    tick();
    idle_in();
    for (int k = 1; k <= TC; k++) begin
      s_ack = (k == 4) ? 4'b1000 : 4'b0000;
      #1;
      chk($sformatf("to_k%0d_ack", k), 64'(m_ack), 64'd0);
      chk($sformatf("to_k%0d_busy", k), 64'(m_busy), 64'd1);
      tick();
    end
    s_ack = '0;
    #1;
    chk("to_ack", 64'(m_ack), 64'd1);
    chk("to_err", 64'(m_err), 64'd1);
    chk("to_rd", 64'(m_rd_data), 64'd0);
    chk("to_sreq", 64'(s_req), 64'd0);
    tick();
    #1;
    chk_quiet("to_after");

    // illegal requests
    illegal("ill_2hot", 4'b0110, 1'b0, 1'b1);
    illegal("ill_nosel", 4'b0000, 1'b1, 1'b0);
    illegal("ill_wrrd", 4'b0001, 1'b1, 1'b1);

    // sync_reset collides with a slave ack
    issue(4'b0100, 1'b0, 1'b1, 64'h5000, 32'h0);
    tick();
    idle_in();
    tick();
    sync_reset = 1'b1;
    s_ack      = 4'b0100;
    #1;
    chk("sr_ack", 64'(m_ack), 64'd0);
    chk("sr_pass", 64'(s_sync), 64'd1);
    tick();
    sync_reset = 1'b0;
    s_ack      = '0;
    #1;
    chk_quiet("sr_after");
    chk("sr_addr", s_addr, 64'd0);
    chk("sr_rden", 64'(s_rd_en), 64'd0);
    chk("sr_pass0", 64'(s_sync), 64'd0);

    // async reset mid-wait, then a fresh request
    issue(4'b1000, 1'b0, 1'b1, 64'h6000, 32'h0);
    tick();
    idle_in();
    #1;
    chk("ar_busy", 64'(m_busy), 64'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk_quiet("ar_rst");
    chk("ar_addr", s_addr, 64'd0);
    chk("ar_rden", 64'(s_rd_en), 64'd0);
    #1;
    rstn = 1'b1;
    tick();
    issue(4'b0010, 1'b0, 1'b1, 64'h7000, 32'h0);
    tick();
    idle_in();
    s_ack = 4'b0010;
    #1;
    chk("ar_new_ack", 64'(m_ack), 64'd1);
    chk("ar_new_err", 64'(m_err), 64'd0);
    chk("ar_new_rd", 64'(m_rd_data), 64'h11111111);
    tick();
    s_ack = '0;
    #1;
    chk_quiet("ar_new_after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/slv_fsm_mc.md
# slv_fsm_mc

Multi-channel register-slave access FSM. It sits between the register master interface and the external/internal register slaves. It accepts one single-cycle request at a time and forwards it to one of NUM_SLV downstream channels, selected by a one-hot decoder vector. It returns the selected channel's acknowledge and read data. It adds an access timeout, an error response for illegal requests, and a busy indication, none of which the single-channel FSM has.

## Interface
- ADDR_WIDTH, 64, request address width
- DATA_WIDTH, 32, read/write data width
- NUM_SLV, 4, number of downstream slave channels (≥1)
- TIMEOUT_CYC, 256, cycles to wait for a slave ack before an error response; 0 disables the timeout
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- mst__fsm__req_vld  in  1  single-cycle request pulse
- mst__fsm__addr  in  ADDR_WIDTH  request address
- mst__fsm__wr_en  in  1  write request
- mst__fsm__rd_en  in  1  read request
- mst__fsm__wr_data  in  DATA_WIDTH  write data
- mst__fsm__slv_sel  in  NUM_SLV  one-hot channel select from the address decoder
- mst__fsm__sync_reset  in  1  synchronous abort
- fsm__mst__ack_vld  out  1  response pulse
- fsm__mst__err  out  1  error qualifier, valid with ack_vld
- fsm__mst__rd_data  out  DATA_WIDTH  read data; 0 unless ack_vld is high and err is low
- fsm__mst__busy  out  1  high when state ≠ IDLE
- fsm__slv__req_vld  out  NUM_SLV  per-channel request, level until ack
- fsm__slv__addr / fsm__slv__wr_data  out  ADDR_WIDTH / DATA_WIDTH  latched request fields, shared by all channels
- fsm__slv__wr_en / fsm__slv__rd_en  out  1  latched enables, shared by all channels
- slv__fsm__ack_vld  in  NUM_SLV  per-channel ack
- slv__fsm__rd_data  in  NUM_SLV*DATA_WIDTH  per-channel read data, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- fsm__slv__sync_reset  out  1  equals mst__fsm__sync_reset, combinational

## Operation
- States:
  - IDLE: no access in progress.
  - WAIT_ACK: waiting for the selected slave.
  - ERR_RSP: one-cycle error response.
- IDLE, with req_vld high and sync_reset low:
  - The request is legal when slv_sel is exactly one-hot and wr_en XOR rd_en is 1. A legal request latches addr, wr_data, wr_en, rd_en and slv_sel, and the FSM goes to WAIT_ACK.
  - An illegal request goes to ERR_RSP and latches nothing.
- WAIT_ACK:
  - fsm__slv__req_vld[i] = sel_ff[i].
  - When ack of the selected channel (slv__fsm__ack_vld & sel_ff, non-zero) is seen: fsm__mst__ack_vld=1 and err=0 in the same cycle (combinational). rd_data is the selected channel's data for a read and 0 for a write. Next state is IDLE.
  - Acks on non-selected channels are ignored.
  - When the timeout count reaches TIMEOUT_CYC-1 with no ack, next state is ERR_RSP.
  - A real ack in the same cycle as the timeout wins: normal response, no error.
- ERR_RSP: ack_vld=1, err=1, rd_data=0 for one cycle, then IDLE.
- sync_reset high in any state:
  - Next state is IDLE; the counter and latched fields clear.
  - No ack is issued to the master, even if a slave ack arrives in the same cycle.
  - A request arriving with sync_reset high is dropped.
- req_vld seen while busy is ignored. The master must not issue a request while busy=1.
- Outside WAIT_ACK, all fsm__slv__* request/field outputs are 0.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYC+1).
  - Clears on entry to WAIT_ACK and counts once per cycle in WAIT_ACK.
  - Saturates; never wraps.

## Timing
- Reset value of every output is 0; state resets to IDLE and the counter to 0.
- Request accepted at cycle T → fsm__slv__req_vld and fields valid from T+1.
- Slave ack at cycle A → master ack at A, same cycle. fsm__slv__req_vld drops at A+1. busy low at A+1. The next request can be accepted at A+1.
- Slave ack in the first WAIT_ACK cycle (T+1) is legal. Minimum request-to-ack latency is 1 cycle.
- Timeout with no ack: error ack at cycle T+TIMEOUT_CYC+1.
- Illegal request at T: error ack at T+1.

## Structure
- Package slv_fsm_pkg holds:
  - the state enum (IDLE, WAIT_ACK, ERR_RSP);
  - a function computing the timeout counter width;
  - an is_onehot function.
- Sub-module slv_rsp_mux: one-hot AND-OR mux of slv__fsm__ack_vld and slv__fsm__rd_data under sel_ff. It outputs sel_ack and sel_rd_data and is parameterised by NUM_SLV and DATA_WIDTH.

## Test plan
- Read, channel 2, slave acks 3 cycles after req → fsm__slv__req_vld=4'b0100 for 3 cycles; master ack with rd_data=0xDEADBEEF and err=0; busy low next cycle.
- Write to channel 0 with a same-cycle ack in the first WAIT_ACK cycle → one master ack, rd_data=0, err=0; fsm__slv__wr_data equals the latched value during WAIT_ACK.
- TIMEOUT_CYC=8, no ack → ack_vld=1, err=1 exactly at T+9; channel 3 acking mid-wait while channel 1 is selected is ignored.
- Illegal requests: slv_sel=4'b0110, slv_sel=0, and wr_en=rd_en=1 → each gives err ack at T+1; no fsm__slv__req_vld asserted.
- sync_reset asserted in WAIT_ACK in the same cycle as a slave ack → no master ack; IDLE next cycle; all fsm__slv__* outputs 0.
- Async rstn asserted mid-WAIT_ACK → all outputs 0 immediately; a fresh request after reset completes normally.
